// File: rtl/scramble_pkg.sv
// Shared constants and helpers for the 100BASE-TX x^11+x^9+1 scrambler and its self-checker.
// Valid coding, tap positions and the lockup reload value match the far-end descrambler.
// lfsr_step holds on no-valid and applies the all-zero lockup guard only when the register shifts.
package scramble_pkg;

  // Valid coding: how many bits the PCS presents this clk (3 behaves as 1).
  localparam logic [1:0] VALID_NONE = 2'd0;
  localparam logic [1:0] VALID_ONE  = 2'd1;
  localparam logic [1:0] VALID_TWO  = 2'd2;

  // Tap indices for x^11+x^9+1, read twice for the two-bit key.
  localparam int TAP_A = 10;
  localparam int TAP_B = 9;
  localparam int TAP_C = 8;
  localparam int TAP_D = 7;

  // Value reloaded when the register would otherwise lock up at all-zero.
  localparam logic [10:0] LOCKUP_RELOAD = 11'h7FF;

  typedef logic [10:0] lfsr_t;

  // Two key bits for this clk; [1] is the earlier bit in time.
  function automatic logic [1:0] key_bits(input lfsr_t s);
    return {s[TAP_C] ^ s[TAP_A], s[TAP_D] ^ s[TAP_B]};
  endfunction

  // Shift in one or two new bits according to the valid code.
  // An idle cycle holds the state untouched, so a zero seed waits for real traffic before reloading.
  function automatic lfsr_t lfsr_step(input lfsr_t s, input logic [1:0] vld, input logic [1:0] in_bits);
    lfsr_t n;
    n = s;
    case (vld)
      VALID_NONE: n = s;
      VALID_TWO:  n = {s[8:0], in_bits};
      default:    n = {s[9:0], in_bits[1]};
    endcase
    if (vld != VALID_NONE && n == '0) n = LOCKUP_RELOAD;
    return n;
  endfunction

endpackage

// File: rtl/scramble_if.sv
// Transmit-side bus between the PCS and the scrambler: plain bits in, scrambled bits out.
// Bits [1] precede [0] in time on both directions; outputs lag inputs by one clk.
// No backpressure: the scrambler accepts whatever the PCS presents every clk.
interface scramble_if;
  logic [1:0] unscrambled;
  logic [1:0] unscrambled_valid;
  logic       bypass;
  logic       reseed;
  logic [1:0] scrambled;
  logic [1:0] scrambled_valid;
  logic       check_err;

  modport master (
    output unscrambled, unscrambled_valid, bypass, reseed,
    input  scrambled, scrambled_valid, check_err
  );

  modport slave (
    input  unscrambled, unscrambled_valid, bypass, reseed,
    output scrambled, scrambled_valid, check_err
  );
endinterface

// File: rtl/scramble_check.sv
// Self-check: recovers the key stream from the scrambler output and verifies it against its own LFSR.
// Latency: compares one clk after the data is registered; err is sticky until rst.
// No backpressure; bypass/reseed (restart) drops sync and the bit count until 11 fresh bits are seen.
module scramble_check
  import scramble_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] data,
  input  logic [1:0] valid,
  input  logic [1:0] scrambled,
  input  logic       restart,
  output logic       err
);

  logic [1:0] data_q, valid_q;
  logic       restart_q;
  lfsr_t      hist_q, hist_d;
  logic [3:0] cnt_q, cnt_d;
  logic       sync_q, sync_d;
  logic       err_q, err_d;
  logic [1:0] ko, pk, miss;

  // Key bits actually used, and the prediction from the last 11 observed key bits.
  assign ko = scrambled ^ data_q;
  assign pk = key_bits(hist_q);

  // Track history, count observed bits to reach sync, flag any prediction miss once synced.
  always_comb begin
    hist_d = lfsr_step(hist_q, valid_q, ko);
    cnt_d  = cnt_q;
    sync_d = sync_q;
    err_d  = err_q;
    miss   = 2'b00;
    case (valid_q)
      VALID_NONE: miss = 2'b00;
      VALID_TWO: begin
        miss  = ko ^ pk;
        cnt_d = cnt_q + 4'd2;
      end
      default: begin
        miss  = {ko[1] ^ pk[1], 1'b0};
        cnt_d = cnt_q + 4'd1;
      end
    endcase
    if (sync_q && (miss != 2'b00)) err_d = 1'b1;
    if (cnt_d >= 4'd11) begin
      cnt_d  = 4'd11;
      sync_d = 1'b1;
    end
    if (restart_q) begin
      cnt_d  = 4'd0;
      sync_d = 1'b0;
      err_d  = err_q;
    end
  end

  // Align the plain data with the registered scrambler output, and hold checker state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q    <= '0;
      valid_q   <= VALID_NONE;
      restart_q <= 1'b0;
      hist_q    <= LOCKUP_RELOAD;
      cnt_q     <= '0;
      sync_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      data_q    <= data;
      valid_q   <= valid;
      restart_q <= restart;
      hist_q    <= hist_d;
      cnt_q     <= cnt_d;
      sync_q    <= sync_d;
      err_q     <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/scramble.sv
// 100BASE-TX transmit scrambler (x^11+x^9+1), 0/1/2 bits per clk; optional self-check via SCRAMBLE_SELFTEST_EN.
// Latency: exactly 1 clk from unscrambled to scrambled, data scrambled regardless of valid.
// No backpressure: every clk is accepted; reseed overrides the advance, bypass only masks the key.
module scramble
  import scramble_pkg::*;
#(
  parameter lfsr_t SEED = 11'h7FF
)(
  input  logic     clk,
  input  logic     rst,
  scramble_if.slave bus
);

  lfsr_t      lfsr_q, lfsr_d;
  logic [1:0] ks;
  logic [1:0] scrambled_q, scrambled_d;
  logic [1:0] valid_q;

  assign ks = key_bits(lfsr_q);

  // Next LFSR: reseed wins, otherwise advance by the valid count with the lockup guard.
  always_comb begin
    lfsr_d = lfsr_step(lfsr_q, bus.unscrambled_valid, ks);
    if (bus.reseed) lfsr_d = SEED;
  end

  // Output always uses the current key, even on reseed or lockup-reload cycles.
  assign scrambled_d = bus.unscrambled ^ (bus.bypass ? 2'b00 : ks);

  // State and output register; async reset clears outputs immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q      <= SEED;
      scrambled_q <= '0;
      valid_q     <= VALID_NONE;
    end else begin
      lfsr_q      <= lfsr_d;
      scrambled_q <= scrambled_d;
      valid_q     <= bus.unscrambled_valid;
    end
  end

  assign bus.scrambled       = scrambled_q;
  assign bus.scrambled_valid = valid_q;

`ifdef SCRAMBLE_SELFTEST_EN
  logic chk_err;

  scramble_check u_check (
    .clk       (clk),
    .rst       (rst),
    .data      (bus.unscrambled),
    .valid     (bus.unscrambled_valid),
    .scrambled (scrambled_q),
    .restart   (bus.bypass | bus.reseed),
    .err       (chk_err)
  );

  assign bus.check_err = chk_err;
`else
  assign bus.check_err = 1'b0;
`endif

endmodule

// File: tb/tb_scramble.sv
// Directed bench for scramble: hand-computed key stream vectors, zero-seed reload, bypass/reseed,
// serial vs dual-bit equivalence, async reset mid-stream, and the self-check when built with it.
// Inputs driven and outputs sampled on the falling edge.
module tb_scramble;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scramble_if sif ();
  scramble_if sif0 ();

  scramble #(.SEED(11'h7FF)) dut  (.clk(clk), .rst(rst), .bus(sif));
  scramble #(.SEED(11'h000)) dut0 (.clk(clk), .rst(rst), .bus(sif0));

  int checks   = 0;
  int failures = 0;

  // Expected output and LFSR-before for SEED=7FF with data 11, valid 2.
  logic [1:0]  seq1  [5] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10};
  logic [10:0] lfsr1 [5] = '{11'h7FF, 11'h7FC, 11'h7F0, 11'h7C0, 11'h700};

  // Bypass / reseed sequence, all valid=2.
  logic        t5_byp [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        t5_rs  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [1:0]  t5_d   [7] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11};
  logic [1:0]  t5_eo  [7] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b11};
  logic [10:0] t5_el  [7] = '{11'h7FF, 11'h7FC, 11'h7F0, 11'h7C0, 11'h700, 11'h401, 11'h7FF};

  logic        ser_a [2048];
  logic        ser_b [2048];
  int          mism;
  logic [1:0]  exp4;
  logic [10:0] fv;
  logic        seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    sif.unscrambled        = 2'b00;
    sif.unscrambled_valid  = 2'd0;
    sif.bypass             = 1'b0;
    sif.reseed             = 1'b0;
    sif0.unscrambled       = 2'b00;
    sif0.unscrambled_valid = 2'd0;
    sif0.bypass            = 1'b0;
    sif0.reseed            = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_scr",   sif.scrambled, 2'b00);
    check("rst_vld",   sif.scrambled_valid, 2'd0);
    check("rst_err",   sif.check_err, 1'b0);
    check("rst_lfsr",  dut.lfsr_q, 11'h7FF);
    check("rst_lfsr0", dut0.lfsr_q, 11'h000);

    // Dual-bit stream from SEED=7FF; zero-seed instance runs alongside
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sif.unscrambled        = 2'b11;
      sif.unscrambled_valid  = 2'd2;
      sif0.unscrambled       = (k == 0) ? 2'b10 : 2'b11;
      sif0.unscrambled_valid = 2'd2;
      check("t1_lfsr", dut.lfsr_q, lfsr1[k]);
      tick();
      check("t1_scr", sif.scrambled, seq1[k]);
      check("t1_vld", sif.scrambled_valid, 2'd2);
      exp4 = (k == 0) ? 2'b10 : seq1[(k == 0) ? 0 : k - 1];
      check("t4_scr", sif0.scrambled, exp4);
      if (k == 0) check("t4_reload", dut0.lfsr_q, 11'h7FF);
    end
    check("t1_err",  sif.check_err, 1'b0);
    check("t4_err",  sif0.check_err, 1'b0);

    // Async reset mid-stream: outputs clear without a clock edge
    rst = 1'b1;
    #1;
    check("rst_mid_scr", sif.scrambled, 2'b00);
    check("rst_mid_vld", sif.scrambled_valid, 2'd0);
    idle();
    @(negedge clk);
    rst = 1'b0;

    // Valid alternating 0/2: same outputs on valid cycles, LFSR holds on idle
    begin
      int idx;
      idx = 0;
      for (int j = 0; j < 10; j++) begin
        sif.unscrambled       = 2'b11;
        sif.unscrambled_valid = (j % 2 == 1) ? 2'd2 : 2'd0;
        if (j % 2 == 1) begin
          check("t2_lfsr", dut.lfsr_q, lfsr1[idx]);
          tick();
          check("t2_scr", sif.scrambled, seq1[idx]);
          idx++;
        end else begin
          tick();
          check("t2_vld0", sif.scrambled_valid, 2'd0);
          check("t2_hold", dut.lfsr_q, lfsr1[idx]);
        end
      end
    end

    // Bypass, return to scrambling, then reseed with valid data
    do_reset();
    for (int r = 0; r < 7; r++) begin
      sif.unscrambled       = t5_d[r];
      sif.unscrambled_valid = 2'd2;
      sif.bypass            = t5_byp[r];
      sif.reseed            = t5_rs[r];
      check("t5_lfsr", dut.lfsr_q, t5_el[r]);
      tick();
      check("t5_scr", sif.scrambled, t5_eo[r]);
    end
    check("t5_after", dut.lfsr_q, 11'h7FC);

    // Single-bit stream over a full period
    do_reset();
    for (int i = 0; i < 2047; i++) begin
      sif.unscrambled       = 2'b11;
      sif.unscrambled_valid = 2'd1;
      tick();
      ser_a[i] = sif.scrambled[1];
    end
    check("t3_period", dut.lfsr_q, 11'h7FF);
    check("t3_bit8", ser_a[8], 1'b1);
    check("t3_bit9", ser_a[9], 1'b0);

    // Dual-bit stream of the same data must match bit for bit
    do_reset();
    for (int i = 0; i < 1024; i++) begin
      sif.unscrambled       = 2'b11;
      sif.unscrambled_valid = 2'd2;
      tick();
      ser_b[2*i]   = sif.scrambled[1];
      ser_b[2*i+1] = sif.scrambled[0];
    end
    mism = 0;
    for (int i = 0; i < 2047; i++) if (ser_a[i] !== ser_b[i]) mism++;
    check("t3_serial_eq", mism, 0);

`ifdef SCRAMBLE_SELFTEST_EN
    // Self-check: clean stream, then a one-clk corruption of the LFSR
    do_reset();
    for (int i = 0; i < 20; i++) begin
      sif.unscrambled       = 2'(i);
      sif.unscrambled_valid = 2'd2;
      tick();
    end
    check("st_clean", sif.check_err, 1'b0);
    fv = dut.lfsr_q ^ 11'h008;
    force dut.lfsr_q = fv;
    tick();
    release dut.lfsr_q;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (!seen) begin
        tick();
        if (sif.check_err === 1'b1) seen = 1'b1;
      end
    end
    check("st_detect", seen, 1'b1);
    repeat (5) tick();
    check("st_sticky", sif.check_err, 1'b1);
    rst = 1'b1;
    #1;
    check("st_rst", sif.check_err, 1'b0);
    idle();
    @(negedge clk);
    rst = 1'b0;
`else
    // Without the self-check the flag is tied low
    for (int i = 0; i < 20; i++) begin
      sif.unscrambled       = 2'(i);
      sif.unscrambled_valid = 2'd2;
      tick();
    end
    check("st_tied", sif.check_err, 1'b0);
    seen = 1'b0;
    fv   = 11'h000;
`endif

    // After a reset the primary sequence repeats
    do_reset();
    for (int k = 0; k < 5; k++) begin
      sif.unscrambled       = 2'b11;
      sif.unscrambled_valid = 2'd2;
      tick();
      check("rpt_scr", sif.scrambled, seq1[k]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
